// File: rtl/alu_iter.sv
// Handshaked ALU: registered single-cycle ops plus iterative MUL/DIVU/REMU.
// The iterative opcodes and the BUSY state exist only when ALU_MULDIV_EN is defined.
module alu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] res;

   // Single-cycle result, computed straight from the operands at accept.
   always_comb begin
      res = '0;
      case (ctrl)
         4'd0:    res = data1 & data2;
         4'd1:    res = data1 | data2;
         4'd2:    res = data1 + data2;
         4'd3:    res = data1 - data2;
         4'd4:    res = data1 ^ data2;
         4'd5:    res[0] = (data1 == data2);
         4'd6:    res[0] = (data1 != data2);
         4'd7:    res[0] = (data1 < data2);
         4'd8:    res[0] = (data1 >= data2);
         4'd9:    res[0] = ($signed(data1) < $signed(data2));
         4'd10:   res[0] = ($signed(data1) >= $signed(data2));
         default: res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [CNT_W-1:0] cnt;
   logic [3:0]       op;
   logic [WIDTH-1:0] acc;   // product for MUL, partial remainder for DIVU/REMU
   logic [WIDTH-1:0] a_r;   // multiplicand for MUL, dividend/quotient for DIVU/REMU
   logic [WIDTH-1:0] b_r;   // multiplier for MUL, divisor for DIVU/REMU
   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   diff;
   logic             is_iter;

   always_comb begin
      sh      = {acc, a_r[WIDTH-1]};
      diff    = sh - {1'b0, b_r};
      is_iter = (ctrl == 4'd11) || (ctrl == 4'd12) || (ctrl == 4'd13);
   end

   // busy drops once the last iteration has run; the zero-count cycle commits the result.
   assign busy = (state == BUSY) && (cnt != '0);
`else
   assign busy = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out   <= '0;
`ifdef ALU_MULDIV_EN
         cnt   <= '0;
         op    <= '0;
         acc   <= '0;
         a_r   <= '0;
         b_r   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
`ifdef ALU_MULDIV_EN
                  if (is_iter) begin
                     state <= BUSY;
                     cnt   <= CNT_W'(WIDTH);
                     op    <= ctrl;
                     acc   <= '0;
                     a_r   <= data1;
                     b_r   <= data2;
                  end else begin
                     state <= DONE;
                     out   <= res;
                  end
`else
                  state <= DONE;
                  out   <= res;
`endif
               end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                  if (op == 4'd11) begin
                     if (b_r[0]) acc <= acc + a_r;
                     a_r <= a_r << 1;
                     b_r <= b_r >> 1;
                  end else begin
                     // Restoring step: a zero divisor always "fits", giving all-ones / dividend.
                     acc <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                     a_r <= {a_r[WIDTH-2:0], ~diff[WIDTH]};
                  end
               end else begin
                  state <= DONE;
                  out   <= (op == 4'd12) ? a_r : acc;
               end
            end
`endif
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH = 32); iterative checks follow ALU_MULDIV_EN.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  ctrl = 4'd0;
   logic [31:0] data1 = '0;
   logic [31:0] data2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out;
   logic        busy;

   int tests = 0;
   int fails = 0;

   alu_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl(ctrl), .data1(data1), .data2(data2), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present a request for one edge; the block is expected to be idle.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      ctrl     = op;
      data1    = a;
      data2    = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      data1    = $urandom;
      data2    = $urandom;
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      issue(op, a, b);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk(tag, out, exp);
      consume(tag);
   endtask

   task automatic iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
      int lat = 0;
      int bcnt = 0;
      issue(op, a, b);
      while (!out_valid && lat < 100) begin
         if (busy) bcnt++;
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, 32'd33);
      chk({tag, "_busycyc"}, bcnt, 32'd32);
      chk(tag, out, exp);
      consume(tag);
   endtask

   initial begin
      // Reset and idle
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_out", out, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // Single-cycle ops
      single("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0);
      single("sub_wrap", 4'd3, 32'd0, 32'd1, 32'hFFFF_FFFF);
      single("lt_signed", 4'd9, 32'h8000_0000, 32'd1, 32'd1);
      single("ltu", 4'd7, 32'h8000_0000, 32'd1, 32'd0);
      single("ge_eq", 4'd10, 32'd5, 32'd5, 32'd1);
      single("op15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
      single("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
      single("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
      single("ne", 4'd6, 32'd3, 32'd4, 32'd1);
      single("geu", 4'd8, 32'd3, 32'hFFFF_FFFF, 32'd0);

`ifdef ALU_MULDIV_EN
      iter("mul", 4'd11, 32'h1234_5678, 32'h10, 32'h2345_6780);
      iter("divu", 4'd12, 32'd100, 32'd7, 32'd14);
      iter("remu", 4'd13, 32'd100, 32'd7, 32'd2);
      iter("divu_z", 4'd12, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
      iter("remu_z", 4'd13, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);

      // Reset on the 10th BUSY cycle of a DIVU
      issue(4'd12, 32'd100, 32'd7);
      repeat (9) step();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_out", out, 32'd0);
      step();
      rst_n = 1'b1;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      single("post_rst_add", 4'd2, 32'd2, 32'd3, 32'd5);
`else
      // Compiled out: MUL returns 0 on the single-cycle path
      issue(4'd11, 32'd3, 32'd4);
      chk("mul_off_valid", {31'd0, out_valid}, 32'd1);
      chk("mul_off_out", out, 32'd0);
      chk("mul_off_busy", {31'd0, busy}, 32'd0);
      consume("mul_off");
      single("divu_off", 4'd12, 32'd100, 32'd7, 32'd0);
`endif

      // Backpressure: result held while a new request waits
      issue(4'd2, 32'd7, 32'd8);
      ctrl     = 4'd2;
      data1    = 32'd1;
      data2    = 32'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_out", out, 32'd15);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
      step();
      in_valid = 1'b0;
      chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_second_out", out, 32'd2);
      consume("bp_second");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
